// File: rtl/ps2_key_event.sv
// PS/2 scan-byte decoder: folds E0/F0 prefixes into key press/release
// events, suppresses typematic repeats, queues events in a FWFT FIFO.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   rx_valid          strobe: rx_code/rx_ascii carry a received byte
//   rx_code, rx_ascii scan byte and its ASCII lookup
//   ev_valid/ev_ready head-of-FIFO handshake
//   ev_code, ev_ascii head event code (prefixes stripped) and ASCII
//   ev_ext, ev_break  head event had E0 prefix / is a release
//   held, held_code   a key is held / its code (kept after release)
//   press_cnt         two-digit BCD count of accepted presses
//   overflow          sticky: an event was dropped on a full FIFO
module ps2_key_event #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_code,
  input  logic [7:0] rx_ascii,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic [7:0] ev_ascii,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       held,
  output logic [7:0] held_code,
  output logic [7:0] press_cnt,
  output logic       overflow
);

  localparam int AW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXT     = 2'd1;
  localparam logic [1:0] S_BRK     = 2'd2;
  localparam logic [1:0] S_EXT_BRK = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        held_ext;

  logic [17:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic is_e0;
  logic is_f0;
  logic cur_ext;
  logic cur_brk;
  logic key;
  logic press;
  logic release_ev;
  logic is_rpt;
  logic new_press;
  logic push;
  logic pop;
  logic full;
  logic do_push;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  always_comb begin
    is_e0      = (rx_code == 8'hE0);
    is_f0      = (rx_code == 8'hF0);
    cur_ext    = (state == S_EXT) || (state == S_EXT_BRK);
    cur_brk    = (state == S_BRK) || (state == S_EXT_BRK);
    key        = rx_valid && !is_e0 && !is_f0;
    press      = key && !cur_brk;
    release_ev = key && cur_brk;
    // Same key and same E0 flag while held: autorepeat, not a new press
    is_rpt     = press && held && (held_code == rx_code)
                 && (held_ext == cur_ext);
    new_press  = press && !is_rpt;
    push       = new_press || release_ev;
    pop        = ev_valid && ev_ready;
    full       = (count == (AW+1)'(FIFO_DEPTH));
    // A full FIFO still accepts a push when the head leaves this cycle
    do_push    = push && (!full || pop);
  end

  always_comb begin
    state_nxt = state;
    if (rx_valid) begin
      unique case (state)
        S_IDLE: begin
          if (is_e0)      state_nxt = S_EXT;
          else if (is_f0) state_nxt = S_BRK;
          else            state_nxt = S_IDLE;
        end
        S_EXT: begin
          if (is_f0)      state_nxt = S_EXT_BRK;
          else if (is_e0) state_nxt = S_EXT;
          else            state_nxt = S_IDLE;
        end
        S_BRK: begin
          if (is_e0)      state_nxt = S_EXT_BRK;
          else if (is_f0) state_nxt = S_BRK;
          else            state_nxt = S_IDLE;
        end
        S_EXT_BRK: begin
          if (is_e0 || is_f0) state_nxt = S_EXT_BRK;
          else                state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      held      <= 1'b0;
      held_ext  <= 1'b0;
      held_code <= 8'h00;
      press_cnt <= 8'h00;
      overflow  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state <= state_nxt;
      if (new_press) begin
        held      <= 1'b1;
        held_ext  <= cur_ext;
        held_code <= rx_code;
        press_cnt <= bcd_inc(press_cnt);
      end else if (release_ev && held && (held_code == rx_code)
                   && (held_ext == cur_ext)) begin
        held <= 1'b0;
      end
      if (push && full && !pop)
        overflow <= 1'b1;
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !pop)
        count <= count + (AW+1)'(1);
      else if (pop && !do_push)
        count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push)
      mem[wr_ptr] <= {rx_code, rx_ascii, cur_ext, release_ev};
  end

  always_comb begin
    ev_valid = (count != '0);
    ev_code  = mem[rd_ptr][17:10];
    ev_ascii = mem[rd_ptr][9:2];
    ev_ext   = mem[rd_ptr][1];
    ev_break = mem[rd_ptr][0];
  end

endmodule
